// File: rtl/pipe_result_collector.sv
// Collects results from the valid-less 3-stage F pipeline, tracks in-flight
// operand sets with a valid shift register and buffers results in a small FIFO.
module pipe_result_collector #(
   parameter int N     = 10,
   parameter int LAT   = 3,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [N-1:0]             pipe_f,
   input  logic                     flush,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [N-1:0]             out_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [LAT-1:0] vld_sr;
   logic [AW-1:0]  wr_ptr;
   logic [AW-1:0]  rd_ptr;
   logic [N-1:0]   mem [DEPTH];

   logic cap;
   logic full;
   logic pop;
   logic push;
   logic drop;

   // A full FIFO still accepts a result when the head leaves in the same cycle.
   assign cap       = vld_sr[LAT-1];
   assign full      = (count == CW'(DEPTH));
   assign out_valid = (count != '0);
   assign pop       = out_valid & out_ready;
   assign push      = cap & (~full | pop);
   assign drop      = cap & full & ~pop;
   assign out_data  = out_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_sr <= '0;
      end else if (flush) begin
         vld_sr <= '0;
      end else begin
         vld_sr[0] <= in_valid;
         for (int i = 1; i < LAT; i++) begin
            vld_sr[i] <= vld_sr[i-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (drop) begin
            overflow <= 1'b1;
         end
      end
   end

   // Storage is not reset; pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         mem[wr_ptr] <= pipe_f;
      end
   end

endmodule

// File: tb/tb_pipe_result_collector.sv
// Directed bench for pipe_result_collector: upstream pipeline model drives
// pipe_f, a scoreboard queue holds expected results, a monitor pops on handshake.
module tb_pipe_result_collector;

   localparam int N     = 10;
   localparam int LAT   = 3;
   localparam int DEPTH = 4;
   localparam int JUNK  = 1000;

   logic                   clk;
   logic                   rst_n;
   logic                   in_valid;
   logic [N-1:0]           pipe_f;
   logic                   flush;
   logic                   out_valid;
   logic                   out_ready;
   logic [N-1:0]           out_data;
   logic [$clog2(DEPTH):0] count;
   logic                   overflow;

   int assertions = 0;
   int failures   = 0;
   int exp_q[$];

   logic [N-1:0] up_val;
   logic [N-1:0] dl [LAT];

   pipe_result_collector #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .pipe_f    (pipe_f),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .count     (count),
      .overflow  (overflow)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Upstream pipeline model: value issued at edge k is on pipe_f for edge k+LAT.
   always @(posedge clk) begin
      dl[0] <= up_val;
      for (int i = 1; i < LAT; i++) begin
         dl[i] <= dl[i-1];
      end
   end
   assign pipe_f = dl[LAT-1];

   function automatic void checkOutput(input string name, input int actual, input int expected);
      assertions++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
      end
   endfunction

   // Monitor: a handshake completes at the next edge, so compare the head now.
   always @(negedge clk) begin
      if (rst_n && !flush && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            assertions++;
            failures++;
            $display("[TB] FAIL sb_unexpected: got %0d, expected nothing at %0t", out_data, $time);
         end else begin
            checkOutput("sb_data", int'(out_data), exp_q.pop_front());
         end
      end
   end

   // One clock cycle of stimulus; returns 1 time unit after the edge.
   task automatic applyStimulus(input bit iv, input int v, input bit rdy, input bit fl, input bit keep);
      in_valid  = iv;
      up_val    = iv ? N'(v) : N'(JUNK);
      out_ready = rdy;
      flush     = fl;
      if (fl) exp_q.delete();
      if (iv && keep && !fl) exp_q.push_back(v);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cycles, input bit rdy);
      for (int i = 0; i < cycles; i++) applyStimulus(0, 0, rdy, 0, 0);
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      flush     = 1'b0;
      up_val    = N'(JUNK);
      #12;
      checkOutput("rst_out_valid", int'(out_valid), 0);
      checkOutput("rst_count", int'(count), 0);
      checkOutput("rst_out_data", int'(out_data), 0);
      checkOutput("rst_overflow", int'(overflow), 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] single result latency");
      applyStimulus(1, 37, 0, 0, 1);
      idle(2, 0);
      checkOutput("lat_early_count", int'(count), 0);
      idle(1, 0);
      checkOutput("lat_out_valid", int'(out_valid), 1);
      checkOutput("lat_out_data", int'(out_data), 37);
      checkOutput("lat_count", int'(count), 1);
      idle(1, 1);
      checkOutput("pop_count", int'(count), 0);
      checkOutput("pop_out_valid", int'(out_valid), 0);

      $display("[TB] fill four then drain");
      for (int i = 1; i <= 4; i++) applyStimulus(1, i, 0, 0, 1);
      idle(3, 0);
      checkOutput("fill_count", int'(count), 4);
      checkOutput("fill_overflow", int'(overflow), 0);
      checkOutput("fill_head", int'(out_data), 1);
      idle(4, 1);
      checkOutput("drain_count", int'(count), 0);

      $display("[TB] overflow drop");
      for (int i = 1; i <= 4; i++) applyStimulus(1, 10 + i, 0, 0, 1);
      applyStimulus(1, 9, 0, 0, 0);
      idle(3, 0);
      checkOutput("ovf_flag", int'(overflow), 1);
      checkOutput("ovf_count", int'(count), 4);
      idle(4, 1);
      checkOutput("ovf_drain_count", int'(count), 0);
      checkOutput("ovf_sticky", int'(overflow), 1);

      $display("[TB] flush with buffered and in-flight results");
      applyStimulus(1, 50, 0, 0, 1);
      applyStimulus(1, 51, 0, 0, 1);
      idle(1, 0);
      applyStimulus(1, 52, 0, 0, 1);
      applyStimulus(1, 53, 0, 0, 1);
      checkOutput("pre_flush_count", int'(count), 2);
      applyStimulus(1, 54, 1, 1, 0);
      checkOutput("flush_count", int'(count), 0);
      checkOutput("flush_out_valid", int'(out_valid), 0);
      checkOutput("flush_overflow", int'(overflow), 0);
      idle(5, 1);
      checkOutput("flush_after_count", int'(count), 0);

      $display("[TB] full with simultaneous pop");
      for (int i = 5; i <= 8; i++) applyStimulus(1, i, 0, 0, 1);
      applyStimulus(1, 9, 0, 0, 1);
      idle(2, 0);
      applyStimulus(0, 0, 1, 0, 0);
      checkOutput("fullpop_count", int'(count), 4);
      checkOutput("fullpop_overflow", int'(overflow), 0);
      checkOutput("fullpop_head", int'(out_data), 6);
      idle(4, 1);
      checkOutput("fullpop_drain", int'(count), 0);

      $display("[TB] continuous stream");
      for (int i = 0; i < 12; i++) begin
         if (i < 8) applyStimulus(1, 20 + i, 1, 0, 1);
         else       applyStimulus(0, 0, 1, 0, 0);
         checkOutput("stream_count_le1", int'(count <= 1), 1);
         if (i == 3) begin
            checkOutput("stream_first_valid", int'(out_valid), 1);
            checkOutput("stream_first_data", int'(out_data), 20);
         end
      end
      idle(2, 1);
      checkOutput("stream_end_count", int'(count), 0);

      $display("[TB] asynchronous reset mid-stream");
      applyStimulus(1, 60, 0, 0, 1);
      applyStimulus(1, 61, 0, 0, 1);
      idle(2, 0);
      checkOutput("prerst_count", int'(count), 1);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      checkOutput("arst_out_valid", int'(out_valid), 0);
      checkOutput("arst_count", int'(count), 0);
      checkOutput("arst_out_data", int'(out_data), 0);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(1, 70, 0, 0, 1);
      idle(2, 0);
      checkOutput("postrst_early", int'(count), 0);
      idle(1, 0);
      checkOutput("postrst_count", int'(count), 1);
      checkOutput("postrst_data", int'(out_data), 70);
      idle(2, 1);
      checkOutput("postrst_drain", int'(count), 0);

      checkOutput("sb_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
      $finish;
   end

endmodule
